// File: rtl/drum_pkg.sv
// Shared types and constants for the drum strike detector and its zone classifier.
package drum_pkg;

    localparam int unsigned NUM_DRUMS = 8;

    typedef logic [3:0] drum_code_t;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StHoldoff
    } strike_state_t;

    function automatic drum_code_t make_drum_code(input logic row, input logic [1:0] zone);
        return {1'b0, row, zone};
    endfunction

endpackage

// File: rtl/drum_zone_classifier.sv
// Combinational mapping of stick yaw/pitch onto one of eight drums (4 yaw zones x 2 rows).
module drum_zone_classifier
    import drum_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int          YAW_B0     = -6000,
    parameter int          YAW_B1     = 0,
    parameter int          YAW_B2     = 6000,
    parameter int          PITCH_HIGH = 3000
) (
    input  logic signed [DATA_W-1:0] yaw,
    input  logic signed [DATA_W-1:0] pitch,
    output drum_code_t               drum_code
);

    localparam logic signed [DATA_W-1:0] B0 = DATA_W'(YAW_B0);
    localparam logic signed [DATA_W-1:0] B1 = DATA_W'(YAW_B1);
    localparam logic signed [DATA_W-1:0] B2 = DATA_W'(YAW_B2);
    localparam logic signed [DATA_W-1:0] PH = DATA_W'(PITCH_HIGH);

    logic [1:0] zone;
    logic       row;

    always_comb begin
        if (yaw < B0) begin
            zone = 2'd0;
        end else if (yaw < B1) begin
            zone = 2'd1;
        end else if (yaw < B2) begin
            zone = 2'd2;
        end else begin
            zone = 2'd3;
        end
        row       = (pitch >= PH);
        drum_code = make_drum_code(row, zone);
    end

endmodule

// File: rtl/drum_strike_detector.sv
// Pitch-rate strike detector: arm on downswing, fire on rebound, then hold off re-triggers.
// Optional strike velocity output is built when DRUM_STRIKE_VELOCITY_EN is defined.
module drum_strike_detector
    import drum_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned STRIKE_THRESH   = 4000,
    parameter int unsigned RELEASE_THRESH  = 1000,
    parameter int unsigned ARM_TIMEOUT     = 50,
    parameter int unsigned HOLDOFF_SAMPLES = 20,
    parameter int          YAW_B0          = -6000,
    parameter int          YAW_B1          = 0,
    parameter int          YAW_B2          = 6000,
    parameter int          PITCH_HIGH      = 3000,
    parameter int unsigned VEL_SHIFT       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] rate,
    input  logic signed [DATA_W-1:0] yaw,
    input  logic signed [DATA_W-1:0] pitch,
    output logic                     drum_trigger_valid,
    output logic [3:0]               drum_code,
    output logic [6:0]               strike_velocity,
    output logic                     busy
);

    // One counter serves both the arm timeout and the holdoff window.
    localparam int unsigned CNT_MAX = (ARM_TIMEOUT > HOLDOFF_SAMPLES) ? ARM_TIMEOUT
                                                                      : HOLDOFF_SAMPLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int unsigned ARM_LAST_I  = (ARM_TIMEOUT == 0) ? 0 : ARM_TIMEOUT - 1;
    localparam int unsigned HOLD_LAST_I = (HOLDOFF_SAMPLES == 0) ? 0 : HOLDOFF_SAMPLES - 1;
    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_LAST_I);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);

    // Thresholds live in DATA_W+1 bits so a full-scale negative sample compares correctly.
    localparam int                     STRIKE_NEG_I  = -int'(STRIKE_THRESH);
    localparam int                     RELEASE_NEG_I = -int'(RELEASE_THRESH);
    localparam logic signed [DATA_W:0] STRIKE_NEG    = (DATA_W+1)'(STRIKE_NEG_I);
    localparam logic signed [DATA_W:0] RELEASE_NEG   = (DATA_W+1)'(RELEASE_NEG_I);

    if (ARM_TIMEOUT == 0) begin : g_bad_timeout
        $error("ARM_TIMEOUT must be at least 1");
    end
    if (RELEASE_THRESH >= STRIKE_THRESH) begin : g_bad_thresh
        $error("RELEASE_THRESH must be below STRIKE_THRESH");
    end
    if (VEL_SHIFT > DATA_W) begin : g_bad_shift
        $error("VEL_SHIFT must not exceed DATA_W");
    end

    strike_state_t            state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] peak_q, peak_d;
    drum_code_t               arm_code_q, arm_code_d;
    drum_code_t               code_q, code_d;
    logic                     trig_q, trig_d;
    drum_code_t               zone_code;
    logic signed [DATA_W:0]   rate_ext;

    assign rate_ext = {rate[DATA_W-1], rate};

    drum_zone_classifier #(
        .DATA_W    (DATA_W),
        .YAW_B0    (YAW_B0),
        .YAW_B1    (YAW_B1),
        .YAW_B2    (YAW_B2),
        .PITCH_HIGH(PITCH_HIGH)
    ) u_classifier (
        .yaw      (yaw),
        .pitch    (pitch),
        .drum_code(zone_code)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        arm_code_d = arm_code_q;
        code_d     = code_q;
        trig_d     = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (sample_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rate_ext < STRIKE_NEG) begin
                        state_d    = StArmed;
                        peak_d     = rate;
                        arm_code_d = zone_code;
                        cnt_d      = '0;
                    end
                end
                StArmed: begin
                    if (rate < peak_q) begin
                        peak_d     = rate;
                        arm_code_d = zone_code;
                    end
                    // A releasing sample is always above the peak, so arm_code_q is final here.
                    if (rate_ext >= RELEASE_NEG) begin
                        trig_d  = 1'b1;
                        code_d  = arm_code_q;
                        cnt_d   = '0;
                        state_d = (HOLDOFF_SAMPLES == 0) ? StIdle : StHoldoff;
                    end else if (cnt_q == ARM_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHoldoff: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            peak_q     <= '0;
            arm_code_q <= '0;
            code_q     <= '0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            arm_code_q <= arm_code_d;
            code_q     <= code_d;
            trig_q     <= trig_d;
        end
    end

    assign drum_trigger_valid = trig_q;
    assign drum_code          = code_q;
    assign busy               = (state_q != StIdle);

`ifdef DRUM_STRIKE_VELOCITY_EN
    logic signed [DATA_W:0] peak_ext;
    logic        [DATA_W:0] peak_mag;
    logic        [DATA_W:0] mag_shifted;
    logic        [6:0]      vel_sat;
    logic        [6:0]      vel_q;

    assign peak_ext    = {peak_q[DATA_W-1], peak_q};
    assign peak_mag    = -peak_ext;
    assign mag_shifted = peak_mag >> VEL_SHIFT;

    always_comb begin
        if (mag_shifted > (DATA_W+1)'(127)) begin
            vel_sat = 7'd127;
        end else begin
            vel_sat = mag_shifted[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vel_q <= '0;
        end else if (trig_d) begin
            vel_q <= vel_sat;
        end
    end

    assign strike_velocity = vel_q;
`else
    assign strike_velocity = 7'd0;
`endif

endmodule

// File: tb/tb_drum_strike_detector.sv
// Directed self-checking bench for drum_strike_detector at default parameters.
module tb_drum_strike_detector;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] rate = '0;
    logic signed [15:0] yaw = '0;
    logic signed [15:0] pitch = '0;
    logic               drum_trigger_valid;
    logic [3:0]         drum_code;
    logic [6:0]         strike_velocity;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    int p0;

    drum_strike_detector dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .sample_valid      (sample_valid),
        .rate              (rate),
        .yaw               (yaw),
        .pitch             (pitch),
        .drum_trigger_valid(drum_trigger_valid),
        .drum_code         (drum_code),
        .strike_velocity   (strike_velocity),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (drum_trigger_valid) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_vel(input string tag, input int exp);
`ifdef DRUM_STRIKE_VELOCITY_EN
        check_eq(tag, int'(strike_velocity), exp);
`else
        check_eq(tag, int'(strike_velocity), 0);
`endif
    endtask

    // Presents one sample for one clock; returns at the negedge after it was consumed.
    task automatic send(input int r);
        @(negedge clk);
        sample_valid = 1'b1;
        rate = 16'(r);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send(0);
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_trig", int'(drum_trigger_valid), 0);
        check_eq("rst_code", int'(drum_code), 0);
        check_eq("rst_vel", int'(strike_velocity), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // Basic strike: peak -9000, yaw 2000 -> zone 2, row 0
        yaw = 16'sd2000; pitch = 16'sd0;
        send(0);
        send(-5000);
        check_eq("t1_busy_armed", int'(busy), 1);
        send(-9000);
        send(-3000);
        check_eq("t1_no_early", int'(drum_trigger_valid), 0);
        send(-500);
        check_eq("t1_trig", int'(drum_trigger_valid), 1);
        check_eq("t1_code", int'(drum_code), 2);
        check_vel("t1_vel", 35);
        @(negedge clk);
        check_eq("t1_one_cycle", int'(drum_trigger_valid), 0);
        check_eq("t1_holdoff_busy", int'(busy), 1);
        send_zeros(19);
        check_eq("t1_busy_h19", int'(busy), 1);
        send(0);
        check_eq("t1_busy_h20", int'(busy), 0);

        // Upper row, classification latched at peak; later and tied samples don't re-latch
        yaw = -16'sd8000; pitch = 16'sd4000;
        send(-20000);
        yaw = 16'sd8000; pitch = 16'sd0;
        send(-10000);
        send(-20000);
        send(-500);
        check_eq("t2_trig", int'(drum_trigger_valid), 1);
        check_eq("t2_code", int'(drum_code), 4);
        check_vel("t2_vel", 78);
        send_zeros(20);

        // Second strike inside holdoff is ignored
        yaw = 16'sd2000; pitch = 16'sd0;
        p0 = pulse_cnt;
        send(-5000); send(-500);
        send_zeros(10);
        send(-5000); send(-9000); send(-500);
        check_eq("t3_suppressed", pulse_cnt, p0 + 1);
        send_zeros(7);
        check_eq("t3_holdoff_end", int'(busy), 0);
        // 25-sample gap: both strikes fire
        p0 = pulse_cnt;
        send(-5000); send(-500);
        send_zeros(25);
        send(-5000); send(-500);
        check_eq("t3_both_fire", pulse_cnt, p0 + 2);
        send_zeros(20);

        // Arm timeout: held downswing never fires
        p0 = pulse_cnt;
        for (int i = 0; i < 60; i++) begin
            send(-5000);
            if (i == 49) check_eq("t4_busy_s49", int'(busy), 1);
            if (i == 50) check_eq("t4_busy_s50", int'(busy), 0);
        end
        check_eq("t4_no_pulse", pulse_cnt, p0);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        check_eq("t4_en_idle", int'(busy), 0);
        enable = 1'b1;

        // Exact thresholds
        send(-4000);
        check_eq("t5_eq_strike_idle", int'(busy), 0);
        send(-4001);
        check_eq("t5_arm", int'(busy), 1);
        send(-1000);
        check_eq("t5_eq_release_fire", int'(drum_trigger_valid), 1);
        check_eq("t5_code", int'(drum_code), 2);
        send_zeros(20);

        // enable falls together with a releasing sample: no pulse, code retained
        yaw = 16'sd8000; pitch = 16'sd4000;
        p0 = pulse_cnt;
        send(-5000);
        @(negedge clk);
        enable = 1'b0; sample_valid = 1'b1; rate = -16'sd500;
        @(negedge clk);
        sample_valid = 1'b0;
        check_eq("t6_en_trig", int'(drum_trigger_valid), 0);
        check_eq("t6_en_busy", int'(busy), 0);
        check_eq("t6_en_code", int'(drum_code), 2);
        enable = 1'b1;
        send(-500);
        check_eq("t6_no_pulse", pulse_cnt, p0);

        // Reset mid-swing
        send(-5000);
        check_eq("t7_armed", int'(busy), 1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_eq("t7_rst_busy", int'(busy), 0);
        check_eq("t7_rst_code", int'(drum_code), 0);
        check_eq("t7_rst_trig", int'(drum_trigger_valid), 0);
        @(negedge clk); rst_n = 1'b1;
        send(-500);
        check_eq("t7_no_pulse", pulse_cnt, p0);

        // Back-to-back strobes, full-scale negative peak, boundary yaw/pitch -> code 7
        yaw = 16'sd6000; pitch = 16'sd3000;
        @(negedge clk);
        sample_valid = 1'b1; rate = -16'sd32768;
        @(negedge clk);
        rate = -16'sd500;
        @(negedge clk);
        sample_valid = 1'b0;
        check_eq("t8_trig", int'(drum_trigger_valid), 1);
        check_eq("t8_code", int'(drum_code), 7);
        check_vel("t8_vel_sat", 127);
        send_zeros(20);

        // Boundary yaw -6000 -> zone 1, pitch just below high -> row 0
        yaw = -16'sd6000; pitch = 16'sd2999;
        send(-5000);
        send(0);
        check_eq("t9_trig", int'(drum_trigger_valid), 1);
        check_eq("t9_code", int'(drum_code), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
